// File: rtl/tokenflow.sv
// tokenflow: synchronous token source emitting x*(x+1) mod 2^w for
// x = 0,1,2,... over a 4-phase req/ack output channel.
//
// Each token is produced by a w-cycle shift-add multiplier (a = x, b = x+1).
// All outputs are registered.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   out_data - token value, valid and stable while out_req = 1
//   out_req  - 4-phase request, high while a token is offered
//   out_ack  - 4-phase acknowledge from the consumer
//
// out_ack is sampled directly, with no synchronizer and no added latency.
// If the consumer is truly asynchronous to clk, a synchronizer must be
// placed outside this block, and the handshake timing shifts by its depth.
module tokenflow #(
  parameter int unsigned w = 16
) (
  input  logic         clk,
  input  logic         reset,
  output logic [w-1:0] out_data,
  output logic         out_req,
  input  logic         out_ack
);

  localparam int unsigned IW = (w > 1) ? $clog2(w) : 1;

  typedef enum logic [1:0] {
    MUL,
    REQ,
    ACKLO
  } state_t;

  state_t         state;
  logic [w-1:0]   x;
  logic [w-1:0]   a;
  logic [w-1:0]   b;
  logic [w-1:0]   acc;
  logic [IW-1:0]  idx;
  logic [w-1:0]   acc_next;

  // Partial-product accumulation for the current bit of b.
  always_comb begin
    acc_next = acc;
    if (b[idx]) begin
      acc_next = acc + (a << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MUL;
      x        <= '0;
      a        <= '0;
      b        <= w'(1);
      acc      <= '0;
      idx      <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        MUL: begin
          acc <= acc_next;
          if (idx == IW'(w - 1)) begin
            out_data <= acc_next;
            out_req  <= 1'b1;
            state    <= REQ;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        REQ: begin
          if (out_ack) begin
            out_req <= 1'b0;
            x       <= x + w'(1);
            state   <= ACKLO;
          end
        end
        ACKLO: begin
          // x has already been advanced, so the next operands are x and x+1.
          if (!out_ack) begin
            a     <= x;
            b     <= x + w'(1);
            acc   <= '0;
            idx   <= '0;
            state <= MUL;
          end
        end
        default: begin
          state <= MUL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tokenflow.sv
module tb_tokenflow;

  logic        clk;
  logic        reset;
  logic [15:0] out_data;
  logic        out_req;
  logic        out_ack;
  logic        ack_mode;   // 1: ack tied to req, 0: ack driven by ack_drv
  logic        ack_drv;

  logic        reset4;
  logic [3:0]  data4;
  logic        req4;
  logic        ack4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] v;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  // Hand-computed x*(x+1) for x = 0..10 (w = 16).
  logic [15:0] seq16 [11] = '{16'd0, 16'd2, 16'd6, 16'd12, 16'd20, 16'd30,
                              16'd42, 16'd56, 16'd72, 16'd90, 16'd110};
  // Hand-computed x*(x+1) mod 16 for x = 0..15 (w = 4).
  logic [3:0] seq4 [16] = '{4'd0, 4'd2, 4'd6, 4'd12, 4'd4, 4'd14, 4'd10, 4'd8,
                            4'd8, 4'd10, 4'd14, 4'd4, 4'd12, 4'd6, 4'd2, 4'd0};

  assign out_ack = ack_mode ? out_req : ack_drv;
  assign ack4    = req4;

  tokenflow #(.w(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_data (out_data),
    .out_req  (out_req),
    .out_ack  (out_ack)
  );

  tokenflow #(.w(4)) dut4 (
    .clk      (clk),
    .reset    (reset4),
    .out_data (data4),
    .out_req  (req4),
    .out_ack  (ack4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] v, input int at);
    exp_t e;
    e.v  = v;
    e.at = at;
    exp_q.push_back(e);
  endtask

  // Advance to the falling edge at which cyc == t (bounded by t itself).
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard monitor for the w=16 instance: every req rise pops one entry.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (out_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_token", out_data, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("token_value", out_data, e.v);
        check("token_time", cyc, e.at);
      end
    end
    prev_req <= out_req;
  end

  // Monitor for the free-running w=4 instance with ack tied to req.
  logic prev_req4 = 1'b0;
  int   k4        = 0;
  int   last4     = 0;
  int   rel4      = 0;
  always @(negedge clk) begin
    if (!reset4 && req4 && !prev_req4) begin
      check("w4_value", data4, seq4[k4 % 16]);
      if (k4 == 0) check("w4_first_time", cyc, rel4 + 4);
      else         check("w4_period", cyc - last4, 6);
      last4 = cyc;
      k4++;
    end
    prev_req4 <= req4;
  end

  initial begin
    int bad;
    int base;
    int t;
    reset    = 1'b1;
    reset4   = 1'b1;
    ack_mode = 1'b0;
    ack_drv  = 1'b0;

    // Reset held for 3 edges: outputs must be idle.
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_req !== 1'b0 || out_data !== 16'd0) bad++;
    end
    check("reset_outputs", bad, 0);
    reset  = 1'b0;
    reset4 = 1'b0;
    rel4   = cyc;
    push(seq16[0], cyc + 16);
    wait_cyc(cyc + 16);

    // Slow consumer: req and data must hold while ack stays low.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_req !== 1'b1 || out_data !== 16'd0) bad++;
      @(negedge clk);
    end
    check("hold_while_waiting", bad, 0);
    ack_drv = 1'b1;
    @(negedge clk);
    check("req_fall", out_req, 1'b0);
    check("data_after_fall", out_data, 16'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_req !== 1'b0) bad++;
    end
    check("acklo_wait", bad, 0);
    ack_drv = 1'b0;
    t = cyc + 17;
    push(seq16[1], t);
    wait_cyc(t);

    // Ack tied to req: tokens every 18 edges.
    ack_mode = 1'b1;
    base = cyc;
    for (int k = 1; k <= 8; k++) push(seq16[k + 1], base + 18 * k);
    wait_cyc(base + 144);

    // At token 90: complete handshake manually, then glitch ack during MUL.
    ack_mode = 1'b0;
    ack_drv  = 1'b1;
    @(negedge clk);
    check("req_fall_manual", out_req, 1'b0);
    ack_drv = 1'b0;
    t = cyc + 17;
    push(seq16[10], t);
    repeat (4) @(negedge clk);
    ack_drv = 1'b1;
    repeat (3) @(negedge clk);
    ack_drv = 1'b0;
    wait_cyc(t);

    // Reset in the middle of MUL.
    ack_drv = 1'b1;
    @(negedge clk);
    ack_drv = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_mul_reset_req", out_req, 1'b0);
    check("mid_mul_reset_data", out_data, 16'd0);
    reset    = 1'b0;
    ack_mode = 1'b1;
    base = cyc;
    for (int k = 0; k <= 5; k++) push(seq16[k], base + 16 + 18 * k);
    wait_cyc(base + 16 + 90);

    // Reset while out_req=1 at x=5.
    reset    = 1'b1;
    ack_mode = 1'b0;
    ack_drv  = 1'b0;
    @(negedge clk);
    check("req_reset_low", out_req, 1'b0);
    check("req_reset_data", out_data, 16'd0);
    reset = 1'b0;
    t = cyc + 16;
    push(seq16[0], t);
    wait_cyc(t + 4);

    check("queue_drained", exp_q.size(), 0);
    check("w4_tokens_seen", (k4 >= 32) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
